// File: rtl/spi_frame_if.sv
// Bundle of the SPI-receiver, image-buffer and inference-core signals seen by
// spi_frame_controller. The master modport is the controller side; the slave
// modport is the environment (receiver, buffer, inference core, host).
`timescale 1ns/1ps
interface spi_frame_if #(
   parameter int ADDR_W = 7
);
   logic              spi_cs_n;
   logic [7:0]        spi_rx_data;
   logic              spi_byte_valid;
   logic              rx_enable;
   logic              byte_taken;
   logic              buf_we;
   logic [ADDR_W-1:0] buf_addr;
   logic [7:0]        buf_wdata;
   logic              infer_start;
   logic              infer_done;
   logic              frame_ready;
   logic [ADDR_W-1:0] byte_count;
   logic [1:0]        err_code;
   logic              overrun;
   logic              clear_error;

   modport master (
      input  spi_cs_n, spi_rx_data, spi_byte_valid, infer_done, clear_error,
      output rx_enable, byte_taken, buf_we, buf_addr, buf_wdata, infer_start,
             frame_ready, byte_count, err_code, overrun
   );

   modport slave (
      output spi_cs_n, spi_rx_data, spi_byte_valid, infer_done, clear_error,
      input  rx_enable, byte_taken, buf_we, buf_addr, buf_wdata, infer_start,
             frame_ready, byte_count, err_code, overrun
   );
endinterface

// File: rtl/spi_frame_controller.sv
// spi_frame_controller: receives one image frame from the SPI byte receiver
// into the image buffer, flags timeout / short frame / overrun, then launches
// one BNN inference and waits for it to complete.
// Optional feature macro SPI_FRAME_CKSUM_EN: a trailing XOR checksum byte is
// expected after the image bytes and verified before the frame is accepted.
`timescale 1ns/1ps
module spi_frame_controller #(
   parameter int IMG_BYTES      = 113,
   parameter int ADDR_W         = 7,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input logic         clk,
   input logic         rst_n,
   spi_frame_if.master bus
);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [ADDR_W-1:0] FULL_CNT = ADDR_W'(IMG_BYTES);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`ifndef SPI_FRAME_CKSUM_EN
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_BYTES - 1);
`endif

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      RECEIVE    = 3'd1,
      FULL       = 3'd2,
      START      = 3'd3,
      WAIT_INFER = 3'd4,
      ERROR      = 3'd5
   } state_t;

   state_t            state, state_nxt;
   logic [1:0]        cs_sync;
   logic              cs_prev;
   logic              cs_high, cs_rise;
   logic [ADDR_W-1:0] byte_cnt, byte_cnt_nxt;
   logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_nxt;
   logic [1:0]        err, err_nxt;
   logic              ovr, ovr_nxt;
   logic              taken, we;
`ifdef SPI_FRAME_CKSUM_EN
   logic [7:0]        xsum, xsum_nxt;
`endif

   // cs_n is high when deasserted, so a rising synced cs_n marks end of transfer
   assign cs_high = cs_sync[1];
   assign cs_rise = cs_sync[1] & ~cs_prev;

   assign bus.rx_enable   = (state == RECEIVE);
   assign bus.frame_ready = (state == FULL);
   assign bus.infer_start = (state == START);
   assign bus.byte_taken  = taken;
   assign bus.buf_we      = we;
   assign bus.buf_addr    = byte_cnt;
   assign bus.buf_wdata   = we ? bus.spi_rx_data : 8'h00;
   assign bus.byte_count  = byte_cnt;
   assign bus.err_code    = err;
   assign bus.overrun     = ovr;

   // Two-flop chip-select synchroniser plus one delay flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync <= 2'b11;
         cs_prev <= 1'b1;
      end else begin
         cs_sync <= {cs_sync[0], bus.spi_cs_n};
         cs_prev <= cs_sync[1];
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         byte_cnt <= '0;
         tmo_cnt  <= '0;
         err      <= 2'd0;
         ovr      <= 1'b0;
`ifdef SPI_FRAME_CKSUM_EN
         xsum     <= 8'h00;
`endif
      end else begin
         state    <= state_nxt;
         byte_cnt <= byte_cnt_nxt;
         tmo_cnt  <= tmo_cnt_nxt;
         err      <= err_nxt;
         ovr      <= ovr_nxt;
`ifdef SPI_FRAME_CKSUM_EN
         xsum     <= xsum_nxt;
`endif
      end
   end

   // Next-state, handshake and counter update logic
   always_comb begin
      state_nxt    = state;
      byte_cnt_nxt = byte_cnt;
      tmo_cnt_nxt  = tmo_cnt;
      err_nxt      = err;
      ovr_nxt      = ovr;
      taken        = 1'b0;
      we           = 1'b0;
`ifdef SPI_FRAME_CKSUM_EN
      xsum_nxt     = xsum;
`endif
      case (state)
         IDLE: begin
            state_nxt    = RECEIVE;
            byte_cnt_nxt = '0;
            tmo_cnt_nxt  = '0;
            err_nxt      = 2'd0;
            ovr_nxt      = 1'b0;
`ifdef SPI_FRAME_CKSUM_EN
            xsum_nxt     = 8'h00;
`endif
         end
         RECEIVE: begin
            taken = bus.spi_byte_valid;
`ifdef SPI_FRAME_CKSUM_EN
            // the byte after the image is the checksum and is never stored
            we = bus.spi_byte_valid && (byte_cnt != FULL_CNT);
`else
            we = bus.spi_byte_valid;
`endif
            // short frame wins over a timeout landing in the same cycle
            if (cs_rise && (byte_cnt != '0) && (byte_cnt < FULL_CNT)) begin
               state_nxt = ERROR;
               err_nxt   = 2'd2;
            end else if (bus.spi_byte_valid) begin
               tmo_cnt_nxt = '0;
`ifdef SPI_FRAME_CKSUM_EN
               if (byte_cnt == FULL_CNT) begin
                  if (bus.spi_rx_data == xsum) begin
                     state_nxt = FULL;
                  end else begin
                     state_nxt = ERROR;
                     err_nxt   = 2'd3;
                  end
               end else begin
                  byte_cnt_nxt = byte_cnt + ADDR_W'(1);
                  xsum_nxt     = xsum ^ bus.spi_rx_data;
               end
`else
               byte_cnt_nxt = byte_cnt + ADDR_W'(1);
               if (byte_cnt == LAST_IDX) begin
                  state_nxt = FULL;
               end else begin
                  state_nxt = RECEIVE;
               end
`endif
            end else if (byte_cnt != '0) begin
               if (tmo_cnt == TMO_LAST) begin
                  state_nxt = ERROR;
                  err_nxt   = 2'd1;
               end else begin
                  tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
               end
            end else begin
               tmo_cnt_nxt = '0;
            end
         end
         FULL: begin
            // late bytes are acknowledged and dropped
            taken = bus.spi_byte_valid;
            if (bus.spi_byte_valid) begin
               ovr_nxt = 1'b1;
            end else begin
               ovr_nxt = ovr;
            end
            if (cs_high) begin
               state_nxt = START;
            end else begin
               state_nxt = FULL;
            end
         end
         START: begin
            state_nxt = WAIT_INFER;
         end
         WAIT_INFER: begin
            if (bus.infer_done) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = WAIT_INFER;
            end
         end
         ERROR: begin
            taken = bus.spi_byte_valid;
            if (bus.clear_error) begin
               state_nxt = IDLE;
            end else begin
               state_nxt = ERROR;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_spi_frame_controller.sv
// Self-checking bench for spi_frame_controller: a table of frame scenarios,
// randomized frames checked against a frame-level reference model, and
// hand-written sequences for timeout, reset mid-frame and ignored events.
`timescale 1ns/1ps
module tb_spi_frame_controller;
   localparam int IMG    = 113;
   localparam int AW     = 7;
   localparam int TMO    = 200;

   typedef struct {
      int         n;
      int         gap;
      int         seed;
      logic [1:0] err;
      int         wr;
      logic       ovr;
      int         inf;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   int   inf_cnt;
   int   tk_cnt;
   logic [AW+7:0] wr_q[$];
   logic [7:0]    fdata [0:127];

   spi_frame_if #(.ADDR_W(AW)) bus();

   spi_frame_controller #(
      .IMG_BYTES(IMG),
      .ADDR_W(AW),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // mid-cycle monitor of buffer writes, inference pulses and handshakes
   always @(negedge clk) begin
      if (bus.buf_we) wr_q.push_back({bus.buf_addr, bus.buf_wdata});
      if (bus.infer_start) inf_cnt <= inf_cnt + 1;
      if (bus.byte_taken) tk_cnt <= tk_cnt + 1;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send_byte(input logic [7:0] d, input int gap);
      bus.spi_byte_valid = 1'b1;
      bus.spi_rx_data    = d;
      step();
      bus.spi_byte_valid = 1'b0;
      repeat (gap - 1) step();
   endtask

   task automatic wait_rx();
      int k;
      k = 0;
      while (bus.rx_enable !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      check("rx_enable_wait", {31'd0, bus.rx_enable}, 32'd1);
   endtask

   // frame-level reference: outcome derived only from the frame length
   function automatic void model(input int n, output logic [1:0] e, output int w,
                                 output logic o, output int inf);
      w   = (n < IMG) ? n : IMG;
      e   = (n < IMG) ? 2'd2 : 2'd0;
      o   = (n > IMG);
      inf = (n >= IMG) ? 1 : 0;
   endfunction

   task automatic run_frame(input int n, input int gap, input logic [1:0] exp_err,
                            input int exp_wr, input logic exp_ovr, input int exp_inf);
      int wr0, inf0, tk0, exp_tk, k, bad;
      logic [7:0] x;
      wait_rx();
      wr0  = wr_q.size();
      inf0 = inf_cnt;
      tk0  = tk_cnt;
      x    = 8'h00;
      exp_tk = n;
      bus.spi_cs_n = 1'b0;
      step();
      step();
      for (int i = 0; i < n; i++) begin
`ifdef SPI_FRAME_CKSUM_EN
         if (i == IMG) send_byte(x, gap);
`endif
         x = x ^ fdata[i];
         send_byte(fdata[i], gap);
      end
`ifdef SPI_FRAME_CKSUM_EN
      if (n == IMG) send_byte(x, gap);
      if (n >= IMG) exp_tk = n + 1;
`endif
      if (exp_inf != 0) begin
         check("frame_ready_full", {31'd0, bus.frame_ready}, 32'd1);
         check("rx_enable_full", {31'd0, bus.rx_enable}, 32'd0);
         check("byte_count_full", {25'd0, bus.byte_count}, IMG);
      end
      bus.spi_cs_n = 1'b1;
      if (exp_err != 2'd0) begin
         k = 0;
         while (bus.err_code == 2'd0 && k < 20) begin
            step();
            k++;
         end
         check("err_code", {30'd0, bus.err_code}, {30'd0, exp_err});
         repeat (5) step();
         check("no_infer_on_err", inf_cnt - inf0, 32'd0);
      end else begin
         k = 0;
         while (inf_cnt == inf0 && k < 20) begin
            step();
            k++;
         end
         check("infer_start_seen", inf_cnt - inf0, 32'd1);
         check("frame_ready_drop", {31'd0, bus.frame_ready}, 32'd0);
         check("overrun", {31'd0, bus.overrun}, {31'd0, exp_ovr});
         check("err_none", {30'd0, bus.err_code}, 32'd0);
         repeat (3) step();
         check("infer_pulses", inf_cnt - inf0, exp_inf);
      end
      check("write_count", wr_q.size() - wr0, exp_wr);
      check("taken_count", tk_cnt - tk0, exp_tk);
      bad = 0;
      for (int j = 0; j < exp_wr && (wr0 + j) < wr_q.size(); j++) begin
         if (wr_q[wr0 + j] !== {AW'(j), fdata[j]}) bad++;
      end
      check("write_contents", bad, 32'd0);
      if (exp_err != 2'd0) begin
         bus.clear_error = 1'b1;
         step();
         bus.clear_error = 1'b0;
         step();
      end else begin
         bus.infer_done = 1'b1;
         step();
         bus.infer_done = 1'b0;
         step();
         check("idle_byte_count", {25'd0, bus.byte_count}, 32'd0);
         check("idle_overrun", {31'd0, bus.overrun}, 32'd0);
      end
   endtask

   initial begin
      vec_t tbl [6];
      logic [1:0] e;
      int w, inf, n, wr0, tk0;
      logic o;

      tbl[0] = '{113, 40, 0,   2'd2 & 2'd0, 113, 1'b0, 1};
      tbl[1] = '{50,  3,  17,  2'd2,        50,  1'b0, 0};
      tbl[2] = '{113, 2,  99,  2'd0,        113, 1'b0, 1};
      tbl[3] = '{115, 2,  5,   2'd0,        113, 1'b1, 1};
      tbl[4] = '{1,   2,  200, 2'd2,        1,   1'b0, 0};
      tbl[5] = '{112, 1,  33,  2'd2,        112, 1'b0, 0};

      n_checks = 0;
      n_errors = 0;
      inf_cnt  = 0;
      tk_cnt   = 0;
      rst_n    = 1'b0;
      bus.spi_cs_n       = 1'b1;
      bus.spi_rx_data    = 8'h5A;
      bus.spi_byte_valid = 1'b1;
      bus.infer_done     = 1'b0;
      bus.clear_error    = 1'b0;
      repeat (3) step();
      check("reset_outputs", {2'd0, bus.rx_enable, bus.byte_taken, bus.buf_we, bus.buf_addr,
            bus.buf_wdata, bus.infer_start, bus.frame_ready, bus.byte_count,
            bus.err_code, bus.overrun}, 32'd0);
      bus.spi_byte_valid = 1'b0;
      rst_n = 1'b1;

      // table-driven frame scenarios
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < 128; i++) fdata[i] = 8'((i + tbl[t].seed) & 255);
         run_frame(tbl[t].n, tbl[t].gap, tbl[t].err, tbl[t].wr, tbl[t].ovr, tbl[t].inf);
      end

      // randomized frames against the reference model
      for (int r = 0; r < 8; r++) begin
         if ($urandom_range(9, 0) < 3) n = $urandom_range(112, 1);
         else n = IMG + $urandom_range(3, 0);
         for (int i = 0; i < 128; i++) fdata[i] = 8'($urandom);
         model(n, e, w, o, inf);
         run_frame(n, $urandom_range(3, 1), e, w, o, inf);
      end

      // reset in the middle of a frame
      wait_rx();
      wr0 = wr_q.size();
      bus.spi_cs_n = 1'b0;
      for (int i = 0; i < 60; i++) send_byte(8'(i), 1);
      rst_n = 1'b0;
      bus.spi_byte_valid = 1'b1;
      bus.spi_rx_data    = 8'h3C;
      #1;
      check("midreset_outputs", {2'd0, bus.rx_enable, bus.byte_taken, bus.buf_we, bus.buf_addr,
            bus.buf_wdata, bus.infer_start, bus.frame_ready, bus.byte_count,
            bus.err_code, bus.overrun}, 32'd0);
      step();
      check("midreset_writes", wr_q.size() - wr0, 32'd60);
      bus.spi_byte_valid = 1'b0;
      bus.spi_cs_n = 1'b1;
      rst_n = 1'b1;
      for (int i = 0; i < 128; i++) fdata[i] = 8'((i * 3) & 255);
      run_frame(IMG, 1, 2'd0, IMG, 1'b0, 1);

      // timeout: stall after 10 bytes
      wait_rx();
      wr0 = wr_q.size();
      tk0 = tk_cnt;
      bus.spi_cs_n = 1'b0;
      for (int i = 0; i < 10; i++) send_byte(8'(i + 1), 1);
      repeat (TMO - 1) step();
      check("tmo_before", {30'd0, bus.err_code}, 32'd0);
      step();
      check("tmo_at", {30'd0, bus.err_code}, 32'd1);
      check("tmo_rx_off", {31'd0, bus.rx_enable}, 32'd0);
      send_byte(8'hEE, 1);
      send_byte(8'hEF, 1);
      check("tmo_writes", wr_q.size() - wr0, 32'd10);
      check("tmo_drained", tk_cnt - tk0, 32'd12);
      bus.infer_done = 1'b1;
      step();
      bus.infer_done = 1'b0;
      check("err_holds", {30'd0, bus.err_code}, 32'd1);
      bus.clear_error = 1'b1;
      step();
      bus.clear_error = 1'b0;
      step();
      check("clear_err", {30'd0, bus.err_code}, 32'd0);
      check("clear_rx", {31'd0, bus.rx_enable}, 32'd1);

      // cs pulse with no bytes is ignored
      bus.spi_cs_n = 1'b1;
      repeat (4) step();
      bus.spi_cs_n = 1'b0;
      repeat (4) step();
      bus.spi_cs_n = 1'b1;
      repeat (5) step();
      check("cs_pulse_err", {30'd0, bus.err_code}, 32'd0);
      check("cs_pulse_rx", {31'd0, bus.rx_enable}, 32'd1);

`ifdef SPI_FRAME_CKSUM_EN
      // checksum match and mismatch
      for (int i = 0; i < 128; i++) fdata[i] = 8'hA5;
      run_frame(IMG, 1, 2'd0, IMG, 1'b0, 1);
      wait_rx();
      wr0 = wr_q.size();
      bus.spi_cs_n = 1'b0;
      for (int i = 0; i < IMG; i++) send_byte(8'hA5, 1);
      send_byte(8'h00, 1);
      check("cksum_bad_err", {30'd0, bus.err_code}, 32'd3);
      check("cksum_bad_writes", wr_q.size() - wr0, IMG);
      bus.spi_cs_n = 1'b1;
      bus.clear_error = 1'b1;
      step();
      bus.clear_error = 1'b0;
      step();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
